// File: rtl/booth_seq_ctrl_if.sv
// Handshake / partial-product bus of booth_seq_ctrl.
//   slave  : the multiplier controller (consumes operands, produces product,
//            drives the partial-product selector code and multiplicand)
//   master : the environment (operand source, product sink, selector)
// Signals:
//   in_valid/in_ready/in_a/in_b    operand handshake (8-bit signed operands)
//   pp_mcand/pp_sel/pp_in          external partial-product selector link
//   abort                          synchronous cancel
//   out_valid/out_ready/out_prod/out_ovf  product handshake (16-bit signed)
//   busy                           controller not idle
interface booth_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] pp_mcand;
  logic [2:0] pp_sel;
  logic [8:0] pp_in;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] out_prod;
  logic       out_ovf;
  logic       busy;

  modport slave (
    input  in_valid, in_a, in_b, pp_in, abort, out_ready,
    output in_ready, pp_mcand, pp_sel, out_valid, out_prod, out_ovf, busy
  );

  modport master (
    output in_valid, in_a, in_b, pp_in, abort, out_ready,
    input  in_ready, pp_mcand, pp_sel, out_valid, out_prod, out_ovf, busy
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller, 8x8 signed -> 16 signed.
// The multiplier is recoded one digit per cycle into a selector code that
// drives an external partial-product selector; the returned partial product
// is shifted and accumulated. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_seq_ctrl_if.slave (operand/product handshakes, selector link,
//          abort, busy)
module booth_seq_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  booth_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc_q;
  logic [2:0]  idx_q;
  logic [2:0]  sel_q;
  logic        ovf_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic [8:0]  b_ext;
  logic [2:0]  trip;
  logic [2:0]  code_d;
  logic [2:0]  shamt;
  logic [15:0] pp_ext;
  logic [15:0] pp_shift;

  function automatic logic [2:0] recode(input logic [2:0] t);
    logic [2:0] c;
    case (t)
      3'b001, 3'b010: c = 3'b001;
      3'b011:         c = 3'b010;
      3'b100:         c = 3'b110;
      3'b101, 3'b110: c = 3'b101;
      default:        c = 3'b000;
    endcase
    return c;
  endfunction

  // Digit i uses triplet b[2i+1:2i-1] with an implicit b[-1]=0.
  // idx_q counts 0..4: cycle 0 only issues digit 0's code, cycles 1..4
  // accumulate digit idx-1 while issuing the code of digit idx.
  always_comb begin
    b_ext    = {b_q, 1'b0};
    trip     = b_ext[{idx_q[1:0], 1'b0} +: 3];
    code_d   = recode(trip);
    shamt    = {idx_q[1:0] - 2'd1, 1'b0};
    pp_ext   = {{7{bus.pp_in[8]}}, bus.pp_in};
    pp_shift = pp_ext << shamt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          sel_q       <= '0;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            acc_q      <= '0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            if (idx_q != 3'd0) begin
              acc_q <= acc_q + pp_shift;
            end
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd4) begin
              state_q     <= DONE;
              sel_q       <= '0;
              out_valid_q <= 1'b1;
            end else begin
              sel_q <= code_d;
              // Negating -128 cannot be represented by the selector.
              ovf_q <= ovf_q | ((a_q == 8'h80) && code_d[2]);
            end
          end
        end
        DONE: begin
          if (bus.abort || bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            sel_q       <= '0;
            if (bus.abort) begin
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          sel_q       <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.pp_mcand  = a_q;
  assign bus.pp_sel    = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  booth_seq_ctrl_if bus();

  booth_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partial-product selector model: 0, +a, +2a, -a, -2a (9-bit wrap).
  logic [8:0] a9;
  always_comb begin
    a9 = {bus.pp_mcand[7], bus.pp_mcand};
    case (bus.pp_sel)
      3'b001:  bus.pp_in = a9;
      3'b010:  bus.pp_in = a9 << 1;
      3'b101:  bus.pp_in = -a9;
      3'b110:  bus.pp_in = -(a9 << 1);
      default: bus.pp_in = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    #12;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_ovf} !== 4'b0000 ||
        bus.out_prod !== 16'h0 || bus.pp_sel !== 3'b000 || bus.pp_mcand !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b busy=%b ov=%b ovf=%b prod=%h sel=%b mc=%h, want all 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.out_ovf, bus.out_prod, bus.pp_sel, bus.pp_mcand);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b want 0", bus.in_ready);
    end
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after_edge: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_products();
    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic [11:0] vs [6];
    logic [15:0] vp [6];
    logic        vo [6];
    logic        vcp[6];
    logic [2:0]  es;
    va[0]=8'd3;   vb[0]=8'd5;   vs[0]={3'b000,3'b000,3'b001,3'b001}; vp[0]=16'd15;   vo[0]=0; vcp[0]=1;
    va[1]=8'd127; vb[1]=8'd127; vs[1]={3'b010,3'b000,3'b000,3'b101}; vp[1]=16'd16129; vo[1]=0; vcp[1]=1;
    va[2]=8'hF9;  vb[2]=8'h80;  vs[2]={3'b110,3'b000,3'b000,3'b000}; vp[2]=16'd896;  vo[2]=0; vcp[2]=1;
    va[3]=8'h80;  vb[3]=8'h01;  vs[3]={3'b000,3'b000,3'b000,3'b001}; vp[3]=16'hFF80; vo[3]=0; vcp[3]=1;
    va[4]=8'h80;  vb[4]=8'hFF;  vs[4]={3'b000,3'b000,3'b000,3'b101}; vp[4]=16'h0;    vo[4]=1; vcp[4]=0;
    va[5]=8'hFB;  vb[5]=8'h55;  vs[5]={3'b001,3'b001,3'b001,3'b001}; vp[5]=16'hFE57; vo[5]=0; vcp[5]=1;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i]);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.pp_sel !== 3'b000) begin
        n_fail++;
        $display("FAIL prod%0d_accept: busy=%b rdy=%b sel=%b want 1 0 000", i, bus.busy, bus.in_ready, bus.pp_sel);
      end
      for (int d = 0; d < 4; d++) begin
        step();
        es = vs[i][3*d +: 3];
        n_checks++;
        if (bus.pp_sel !== es || bus.pp_mcand !== va[i] || bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL prod%0d_digit%0d: sel=%b mc=%h ov=%b want sel=%b mc=%h ov=0",
                   i, d, bus.pp_sel, bus.pp_mcand, bus.out_valid, es, va[i]);
        end
      end
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ovf !== vo[i] || bus.pp_sel !== 3'b000 ||
          (vcp[i] && bus.out_prod !== vp[i])) begin
        n_fail++;
        $display("FAIL prod%0d_result: ov=%b prod=%h ovf=%b sel=%b want ov=1 prod=%h ovf=%b sel=000",
                 i, bus.out_valid, bus.out_prod, bus.out_ovf, bus.pp_sel, vp[i], vo[i]);
      end
      finish_op();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL prod%0d_release: ov=%b rdy=%b busy=%b want 0 1 0", i, bus.out_valid, bus.in_ready, bus.busy);
      end
    end
  endtask

  task automatic test_hold_done();
    start_op(8'd3, 8'd5);
    repeat (5) step();
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'd15 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ov=%b prod=%h ovf=%b rdy=%b want 1 000f 0 0",
                 c, bus.out_valid, bus.out_prod, bus.out_ovf, bus.in_ready);
      end
      step();
    end
    finish_op();
  endtask

  task automatic test_abort_calc();
    start_op(8'd3, 8'h55);
    repeat (3) step();
    n_checks++;
    if (bus.pp_sel !== 3'b001) begin
      n_fail++; $display("FAIL abort_calc_digit2: sel=%b want 001", bus.pp_sel);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.pp_sel !== 3'b000 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_calc_idle: busy=%b ov=%b sel=%b rdy=%b want 0 0 000 1",
               bus.busy, bus.out_valid, bus.pp_sel, bus.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL abort_calc_quiet%0d: ov=%b busy=%b want 0 0", c, bus.out_valid, bus.busy);
      end
    end
  endtask

  task automatic test_abort_done();
    start_op(8'd7, 8'd9);
    repeat (5) step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'd63) begin
      n_fail++; $display("FAIL abort_done_result: ov=%b prod=%h want 1 003f", bus.out_valid, bus.out_prod);
    end
    bus.abort = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_done_idle: ov=%b busy=%b rdy=%b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_abort_idle();
    bus.abort = 1'b1;
    start_op(8'd2, 8'hFD);
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle_accept: busy=%b want 1", bus.busy);
    end
    repeat (5) step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'hFFFA || bus.out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_result: ov=%b prod=%h ovf=%b want 1 fffa 0", bus.out_valid, bus.out_prod, bus.out_ovf);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    start_op(8'd3, 8'd5);
    repeat (5) step();
    bus.in_valid = 1'b1; bus.in_a = 8'd4; bus.in_b = 8'd4;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_same_cycle: busy=%b rdy=%b ov=%b want 0 1 0", bus.busy, bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: busy=%b want 1", bus.busy);
    end
    repeat (5) step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'd16) begin
      n_fail++; $display("FAIL b2b_result: ov=%b prod=%h want 1 0010", bus.out_valid, bus.out_prod);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_calc();
    start_op(8'd127, 8'd127);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.out_ovf} !== 4'b0000 ||
        bus.out_prod !== 16'h0 || bus.pp_sel !== 3'b000 || bus.pp_mcand !== 8'h0) begin
      n_fail++;
      $display("FAIL midcalc_reset: rdy=%b busy=%b ov=%b ovf=%b prod=%h sel=%b mc=%h want all 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.out_ovf, bus.out_prod, bus.pp_sel, bus.pp_mcand);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midcalc_ready: rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy);
    end
    start_op(8'd2, 8'hFD);
    repeat (5) step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prod !== 16'hFFFA || bus.out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL midcalc_next_op: ov=%b prod=%h ovf=%b want 1 fffa 0", bus.out_valid, bus.out_prod, bus.out_ovf);
    end
    finish_op();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_products();
    test_hold_done();
    test_abort_calc();
    test_abort_done();
    test_abort_idle();
    test_back_to_back();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

endmodule

// File: doc/booth_seq_ctrl.md
BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at an 8-bit signed multiplicand, an 8-bit signed multiplier and a 16-bit signed product.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 in_a  input  8  signed multiplicand.
REQ-007 in_b  input  8  signed multiplier, Booth-recoded by this block.
REQ-008 pp_mcand  output  8  registered multiplicand driven to the external partial-product selector.
REQ-009 pp_sel  output  3  selector code {inv, shift[1:0]}: 000=0, 001=+1, 010=+2, 101=-1, 110=-2.
REQ-010 pp_in  input  9  signed partial product returned combinationally by the selector.
REQ-011 abort  input  1  synchronous cancel of the current operation.
REQ-012 out_valid  output  1  product valid.
REQ-013 out_ready  input  1  consumer accepts the product.
REQ-014 out_prod  output  16  signed product.
REQ-015 out_ovf  output  1  selector-overflow flag for this product.
REQ-016 busy  output  1  high when not in IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; an operand transfer occurs on in_valid&in_ready.
REQ-019 On a transfer, the block SHALL register in_a and in_b, clear the accumulator, set the digit index to 0, clear out_ovf and go to CALC.
REQ-020 In CALC, digit i (0..3) SHALL be recoded from the triplet (b[2i+1], b[2i], b[2i-1]), with b[-1]=0.
REQ-021 Recoding SHALL be: 000 and 111 -> code 000; 001 and 010 -> 001; 011 -> 010; 100 -> 110; 101 and 110 -> 101.
REQ-022 Code 100 and code 111 SHALL never be emitted.
REQ-023 pp_sel SHALL be a registered output, valid for the whole CALC cycle of digit i.
REQ-024 pp_mcand SHALL hold the registered in_a for the whole operation.
REQ-025 In each CALC cycle, the accumulator SHALL add sign-extend16(pp_in) << 2i, with arithmetic modulo 2^16.
REQ-026 CALC SHALL take exactly 4 cycles regardless of zero digits; there is no early termination.
REQ-027 If the accepted in_a is -128 and any emitted code is 101 or 110, out_ovf SHALL be set to 1; out_prod is then unspecified.
REQ-028 After digit 3 the FSM SHALL enter DONE with out_valid=1.
REQ-029 Latency: a transfer at edge T SHALL produce out_valid=1 after edge T+5.
REQ-030 In DONE, out_prod and out_ovf SHALL be held stable while out_ready=0.
REQ-031 On out_valid&out_ready the FSM SHALL return to IDLE; in_ready rises the next cycle, so there is no same-cycle back-to-back transfer.
REQ-032 In IDLE and DONE, pp_sel SHALL be 000.
REQ-033 abort=1 in CALC or DONE SHALL force IDLE on the next edge, with out_valid=0 and pp_sel=000; the result is discarded.
REQ-034 abort SHALL have priority over out_ready; abort in IDLE SHALL be ignored, and an in_valid transfer in the same cycle SHALL still be accepted.

Reset
REQ-035 While rst_n=0, all outputs SHALL go to 0 immediately (in_ready=0, busy=0, out_valid=0, out_prod=0, out_ovf=0, pp_sel=000, pp_mcand=0) and the FSM SHALL be in IDLE.
REQ-036 After the first clk edge with rst_n=1, in_ready SHALL be 1.
REQ-037 Reset asserted mid-CALC or mid-DONE SHALL discard the operation with no residual state.

Verification
REQ-038 a=3, b=5 -> pp_sel sequence 001,001,000,000; out_prod=15; out_ovf=0; out_valid at T+5.
REQ-039 a=127, b=127 -> pp_sel sequence 101,000,000,010; out_prod=16129.
REQ-040 a=-7, b=-128 -> pp_sel sequence 000,000,000,110; out_prod=896; a=-128, b=1 -> out_prod=-128 with out_ovf=0.
REQ-041 a=-128, b=-1 -> first code 101; out_ovf=1.
REQ-042 out_ready held 0 for 10 cycles in DONE -> out_prod stable and in_ready=0 throughout; then abort asserted in CALC digit 2 -> IDLE next cycle, out_valid never asserted.
REQ-043 rst_n pulsed low mid-CALC -> outputs 0 immediately; the next operation (a=2, b=-3) gives out_prod=-6.
